// File: rtl/cell_free_list_arb.sv
// cell_free_list_arb: cell buffer free list with round-robin alloc arbitration.
// After reset the list self-initialises with indices 0..NUM_BLOCKS-1 (INIT),
// then serves one alloc grant and one returned index per cycle (RUN).
// Optional build macro FL_DOUBLE_FREE_CHECK_EN adds an allocated bitmap that
// drops frees of indices not currently allocated and flags err_double_free_o.
module cell_free_list_arb #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_BLOCKS = 256,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] alloc_req_i,
  output logic [NUM_REQ-1:0] alloc_gnt_o,
  output logic [ADDR_W-1:0]  alloc_idx_o,
  input  logic               free_valid_i,
  input  logic [ADDR_W-1:0]  free_idx_i,
  output logic               free_ready_o,
`ifdef FL_DOUBLE_FREE_CHECK_EN
  output logic               err_double_free_o,
`endif
  output logic               init_done_o,
  output logic [ADDR_W:0]    free_count_o
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(NUM_BLOCKS);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    head_q, head_d;
  logic [ADDR_W-1:0]    tail_q, tail_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]    init_cnt_q, init_cnt_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic [ADDR_W-1:0]    mem [NUM_BLOCKS];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_wdata;
  logic [ADDR_W-1:0]    head_data;

  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  int unsigned          winner;
  logic                 free_acc;
  logic                 free_app;
  logic                 grant;

`ifdef FL_DOUBLE_FREE_CHECK_EN
  logic [NUM_BLOCKS-1:0] map_q, map_d;
  logic                  err_q, err_d;
`endif

  assign head_data = mem[head_q];

  // Round-robin search: first eligible requester at or after the RR pointer.
  always_comb begin
    elig   = alloc_req_i & ~gnt_q;
    found  = 1'b0;
    winner = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[(32'(rr_q) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = (32'(rr_q) + i) % NUM_REQ;
      end
    end
  end

  // Next-state logic for list pointers, count, arbitration and handshakes.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    init_cnt_d = init_cnt_q;
    rr_d       = rr_q;
    gnt_d      = '0;
    idx_d      = idx_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    free_acc   = 1'b0;
    free_app   = 1'b0;
    grant      = 1'b0;
`ifdef FL_DOUBLE_FREE_CHECK_EN
    map_d      = map_q;
    err_d      = err_q;
`endif
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_wdata  = init_cnt_q;
        tail_d     = tail_q + 1'b1;
        count_d    = count_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = RUN;
`ifdef FL_DOUBLE_FREE_CHECK_EN
        map_d      = '0;
`endif
      end
      RUN: begin
        free_acc = free_valid_i && ready_q;
`ifdef FL_DOUBLE_FREE_CHECK_EN
        // A free of an index not marked allocated completes the handshake but is discarded.
        if (free_acc) begin
          if (map_q[free_idx_i]) begin
            free_app = 1'b1;
            map_d[free_idx_i] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
`else
        free_app = free_acc;
`endif
        if (free_app) begin
          mem_we    = 1'b1;
          mem_wdata = free_idx_i;
          tail_d    = tail_q + 1'b1;
        end
        // No bypass: a free accepted while empty is only grantable next cycle.
        grant = (count_q != '0) && found;
        if (grant) begin
          gnt_d[winner] = 1'b1;
          idx_d         = head_data;
          head_d        = head_q + 1'b1;
          rr_d          = RR_W'((winner + 1) % NUM_REQ);
`ifdef FL_DOUBLE_FREE_CHECK_EN
          map_d[head_data] = 1'b1;
`endif
        end
        count_d = count_q + (ADDR_W+1)'(free_app) - (ADDR_W+1)'(grant);
      end
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN) && (count_d != FULL_CNT);
    done_d  = (state_d == RUN);
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      init_cnt_q <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      init_cnt_q <= init_cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // List storage; contents are rebuilt in INIT so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we) mem[tail_q] <= mem_wdata;
  end

`ifdef FL_DOUBLE_FREE_CHECK_EN
  // Allocated bitmap and sticky double-free flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
      err_q <= 1'b0;
    end else begin
      map_q <= map_d;
      err_q <= err_d;
    end
  end

  assign err_double_free_o = err_q;
`endif

  assign alloc_gnt_o  = gnt_q;
  assign alloc_idx_o  = idx_q;
  assign free_ready_o = ready_q;
  assign init_done_o  = done_q;
  assign free_count_o = count_q;

endmodule

// File: tb/tb_cell_free_list_arb.sv
// Directed self-checking bench for cell_free_list_arb (default parameters).
module tb_cell_free_list_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] alloc_req_i;
  logic [3:0] alloc_gnt_o;
  logic [7:0] alloc_idx_o;
  logic       free_valid_i;
  logic [7:0] free_idx_i;
  logic       free_ready_o;
  logic       init_done_o;
  logic [8:0] free_count_o;
`ifdef FL_DOUBLE_FREE_CHECK_EN
  logic       err_double_free_o;
`endif

  int checks = 0;
  int errors = 0;

  cell_free_list_arb #(.NUM_REQ(4), .NUM_BLOCKS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req_i  (alloc_req_i),
    .alloc_gnt_o  (alloc_gnt_o),
    .alloc_idx_o  (alloc_idx_o),
    .free_valid_i (free_valid_i),
    .free_idx_i   (free_idx_i),
    .free_ready_o (free_ready_o),
`ifdef FL_DOUBLE_FREE_CHECK_EN
    .err_double_free_o (err_double_free_o),
`endif
    .init_done_o  (init_done_o),
    .free_count_o (free_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_rr_idx [5];
  logic [3:0] exp_rr_gnt [5];
  logic [7:0] exp_tail   [5];

  initial begin
    rst_n        = 1'b0;
    alloc_req_i  = 4'b1111;
    free_valid_i = 1'b0;
    free_idx_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   32'(alloc_gnt_o),  0);
    chk("rst_idx",   32'(alloc_idx_o),  0);
    chk("rst_ready", 32'(free_ready_o), 0);
    chk("rst_done",  32'(init_done_o),  0);
    chk("rst_count", 32'(free_count_o), 0);
`ifdef FL_DOUBLE_FREE_CHECK_EN
    chk("rst_err",   32'(err_double_free_o), 0);
`endif
    rst_n = 1'b1;

    // INIT: 256 cycles, no grants despite all requests high.
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk("init_gnt",  32'(alloc_gnt_o),  0);
      chk("init_done", 32'(init_done_o),  0);
      chk("init_rdy",  32'(free_ready_o), 0);
      if (k == 100) chk("init_cnt100", 32'(free_count_o), 100);
    end
    tick();
    chk("init_done_rise", 32'(init_done_o),  1);
    chk("init_count",     32'(free_count_o), 256);
    chk("full_ready",     32'(free_ready_o), 0);
    chk("init_last_gnt",  32'(alloc_gnt_o),  0);

    // Single requester: grant every other cycle, idx 0,1,2.
    alloc_req_i = 4'b0001;
    tick(); chk("r0_g0",  32'(alloc_gnt_o), 4'b0001); chk("r0_i0", 32'(alloc_idx_o), 0);
    tick(); chk("r0_gap0", 32'(alloc_gnt_o), 0);      chk("r0_hold", 32'(alloc_idx_o), 0);
    tick(); chk("r0_g1",  32'(alloc_gnt_o), 4'b0001); chk("r0_i1", 32'(alloc_idx_o), 1);
    tick(); chk("r0_gap1", 32'(alloc_gnt_o), 0);
    tick(); chk("r0_g2",  32'(alloc_gnt_o), 4'b0001); chk("r0_i2", 32'(alloc_idx_o), 2);
    chk("r0_count", 32'(free_count_o), 253);
    chk("r0_ready", 32'(free_ready_o), 1);

    // All four requesting; RR pointer now at 1.
    alloc_req_i = 4'b0000;
    tick(); chk("idle_gnt", 32'(alloc_gnt_o), 0);
    alloc_req_i = 4'b1111;
    exp_rr_gnt[0] = 4'b0010; exp_rr_idx[0] = 8'd3;
    exp_rr_gnt[1] = 4'b0100; exp_rr_idx[1] = 8'd4;
    exp_rr_gnt[2] = 4'b1000; exp_rr_idx[2] = 8'd5;
    exp_rr_gnt[3] = 4'b0001; exp_rr_idx[3] = 8'd6;
    exp_rr_gnt[4] = 4'b0010; exp_rr_idx[4] = 8'd7;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(alloc_gnt_o), 32'(exp_rr_gnt[k]));
      chk("rr_idx", 32'(alloc_idx_o), 32'(exp_rr_idx[k]));
    end
    chk("rr_count", 32'(free_count_o), 248);

    // Drain with req[2]: 248 grants, idx 8..255, one per two cycles.
    alloc_req_i = 4'b0100;
    repeat (495) tick();
    chk("drain_gnt",   32'(alloc_gnt_o),  4'b0100);
    chk("drain_idx",   32'(alloc_idx_o),  255);
    chk("drain_count", 32'(free_count_o), 0);
    tick(); chk("empty_gnt0", 32'(alloc_gnt_o), 0);
    tick(); chk("empty_gnt1", 32'(alloc_gnt_o), 0);
    chk("empty_idx_hold", 32'(alloc_idx_o), 255);
    chk("empty_ready", 32'(free_ready_o), 1);

    // Free 0x2A into empty list: no bypass, grant one cycle later.
    free_valid_i = 1'b1; free_idx_i = 8'h2A;
    tick();
    chk("nobypass_gnt", 32'(alloc_gnt_o),  0);
    chk("nobypass_cnt", 32'(free_count_o), 1);
    free_valid_i = 1'b0;
    tick();
    chk("refill_gnt", 32'(alloc_gnt_o),  4'b0100);
    chk("refill_idx", 32'(alloc_idx_o),  8'h2A);
    chk("refill_cnt", 32'(free_count_o), 0);

    // Build count=5 with 0x50..0x54, then free 0x11 alongside a grant.
    alloc_req_i = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      free_valid_i = 1'b1; free_idx_i = 8'(8'h50 + k);
      tick();
    end
    chk("fill5_cnt", 32'(free_count_o), 5);
    alloc_req_i = 4'b0010; free_idx_i = 8'h11;
    tick();
    free_valid_i = 1'b0;
    chk("simul_cnt", 32'(free_count_o), 5);
    chk("simul_gnt", 32'(alloc_gnt_o),  4'b0010);
    chk("simul_idx", 32'(alloc_idx_o),  8'h50);
    exp_tail[0] = 8'h51; exp_tail[1] = 8'h52; exp_tail[2] = 8'h53;
    exp_tail[3] = 8'h54; exp_tail[4] = 8'h11;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("fifo_gap", 32'(alloc_gnt_o), 0);
      tick();
      chk("fifo_gnt", 32'(alloc_gnt_o), 4'b0010);
      chk("fifo_idx", 32'(alloc_idx_o), 32'(exp_tail[k]));
    end
    chk("fifo_cnt", 32'(free_count_o), 0);
    alloc_req_i = 4'b0000;
    tick();

`ifdef FL_DOUBLE_FREE_CHECK_EN
    // idx 7 is allocated: first free appends, second is a double free.
    free_valid_i = 1'b1; free_idx_i = 8'd7;
    tick();
    chk("df_first_cnt", 32'(free_count_o), 1);
    chk("df_first_err", 32'(err_double_free_o), 0);
    chk("df_ready",     32'(free_ready_o), 1);
    tick();
    free_valid_i = 1'b0;
    chk("df_second_cnt", 32'(free_count_o), 1);
    chk("df_second_err", 32'(err_double_free_o), 1);
    repeat (3) tick();
    chk("df_sticky", 32'(err_double_free_o), 1);
`else
    // Plain build: every accepted free is appended.
    free_valid_i = 1'b1; free_idx_i = 8'd7;
    tick(); chk("app1_cnt", 32'(free_count_o), 1);
    tick(); chk("app2_cnt", 32'(free_count_o), 2);
    free_valid_i = 1'b0;
    tick(); chk("app_hold", 32'(free_count_o), 2);
`endif

    // Mid-operation reset rebuilds the list from 0.
    rst_n = 1'b0;
    #1;
    chk("rst2_count", 32'(free_count_o), 0);
    chk("rst2_done",  32'(init_done_o),  0);
    tick();
    rst_n = 1'b1;
    alloc_req_i = 4'b1000;
    repeat (256) tick();
    chk("rst2_init_done", 32'(init_done_o), 1);
    tick();
    chk("rst2_gnt", 32'(alloc_gnt_o), 4'b1000);
    chk("rst2_idx", 32'(alloc_idx_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
